inst_fetch_queue: RTL and testbench

Instruction fetch stage downstream of the PC-update logic in the RISC-V core. Holds the architectural fetch PC, issues word reads to instruction memory over a valid/ready request channel with in-order responses of any latency, and buffers returned instructions with their PCs in a small FIFO for decode. A branch redirect (taken-branch target from the PC/branch adder) flushes the FIFO and discards in-flight responses.

---
 rtl/inst_fetch_queue.sv | 145 ++++++++++++++
 tb/tb_inst_fetch_queue.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: fetch PC, credit-limited imem request channel, and a small
// instruction FIFO for decode. A redirect flushes the FIFO and drops all
// responses still in flight.
// Optional feature macro: IFETCH_ALIGN_CHECK_EN (misaligned-redirect fault).
module inst_fetch_queue #(
    parameter int               XLEN     = 64,
    parameter logic [XLEN-1:0]  RESET_PC = '0,
    parameter int               DEPTH    = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_resp_valid,
    input  logic [31:0]     imem_resp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [31:0]     inst_data,
    output logic [XLEN-1:0] inst_pc,
    output logic            fetch_fault
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   outst_q, outst_d;
    logic [CW-1:0]   drop_q, drop_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   tag_rd_q, tag_rd_d, tag_wr_q, tag_wr_d;
    logic            fault_q, fault_d;

    // FIFO payload and the PC tags of outstanding requests (no reset needed)
    logic [DEPTH-1:0][31:0]     fifo_data_q, fifo_data_d;
    logic [DEPTH-1:0][XLEN-1:0] fifo_pc_q, fifo_pc_d;
    logic [DEPTH-1:0][XLEN-1:0] tag_q, tag_d;

    logic [CW:0] credit;
    logic        accept, push, pop;

    // Request/accept/response/pop decode and next-state computation
    always_comb begin
        fetch_pc_d  = fetch_pc_q;
        count_d     = count_q;
        outst_d     = outst_q;
        drop_d      = drop_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        tag_rd_d    = tag_rd_q;
        tag_wr_d    = tag_wr_q;
        fault_d     = fault_q;
        fifo_data_d = fifo_data_q;
        fifo_pc_d   = fifo_pc_q;
        tag_d       = tag_q;

        // FIFO entries plus in-flight requests never exceed DEPTH, so a
        // response always finds room.
        credit         = {1'b0, count_q} + {1'b0, outst_q};
        imem_req_valid = !rst && !redirect_valid && !fault_q &&
                         (credit < (CW+1)'(DEPTH));
        imem_req_addr  = fetch_pc_q;
        accept         = imem_req_valid && imem_req_ready;
        push           = imem_resp_valid && (drop_q == '0) && !redirect_valid;
        pop            = (count_q != '0) && inst_ready && !redirect_valid;

        if (accept) begin
            fetch_pc_d       = fetch_pc_q + XLEN'(4);
            tag_d[tag_wr_q]  = fetch_pc_q;
            tag_wr_d         = tag_wr_q + PW'(1);
        end
        if (imem_resp_valid) begin
            tag_rd_d = tag_rd_q + PW'(1);
            if (drop_q != '0)
                drop_d = drop_q - CW'(1);
        end
        outst_d = outst_q + CW'(accept) - CW'(imem_resp_valid);

        if (push) begin
            fifo_data_d[wr_ptr_q] = imem_resp_data;
            fifo_pc_d[wr_ptr_q]   = tag_q[tag_rd_q];
            wr_ptr_d              = wr_ptr_q + PW'(1);
        end
        if (pop)
            rd_ptr_d = rd_ptr_q + PW'(1);
        count_d = count_q + CW'(push) - CW'(pop);

        // Redirect: flush, and drop every response still owed after this cycle
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc & ~XLEN'(3);
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            drop_d     = outst_d;
`ifdef IFETCH_ALIGN_CHECK_EN
            fault_d    = (redirect_pc[1:0] != 2'b00);
`endif
        end
`ifndef IFETCH_ALIGN_CHECK_EN
        fault_d = 1'b0;
`endif
    end

    // Control state with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            count_q    <= '0;
            outst_q    <= '0;
            drop_q     <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            tag_rd_q   <= '0;
            tag_wr_q   <= '0;
            fault_q    <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            count_q    <= count_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            tag_rd_q   <= tag_rd_d;
            tag_wr_q   <= tag_wr_d;
            fault_q    <= fault_d;
        end
    end

    // Storage arrays; contents only matter while covered by count/outstanding
    always_ff @(posedge clk) begin
        fifo_data_q <= fifo_data_d;
        fifo_pc_q   <= fifo_pc_d;
        tag_q       <= tag_d;
    end

    // Head outputs are zero whenever the FIFO is empty
    always_comb begin
        inst_valid  = (count_q != '0);
        inst_data   = inst_valid ? fifo_data_q[rd_ptr_q] : 32'h0;
        inst_pc     = inst_valid ? fifo_pc_q[rd_ptr_q] : '0;
        fetch_fault = fault_q;
    end
endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue: behavioural in-order memory with
// programmable latency, PC/data scoreboard checked on every decode pop.
module tb_inst_fetch_queue;
    logic        clk, rst;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        imem_req_valid, imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        inst_valid, inst_ready;
    logic [31:0] inst_data;
    logic [63:0] inst_pc;
    logic        fetch_fault;

    inst_fetch_queue dut (
        .clk(clk), .rst(rst),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_data(inst_data), .inst_pc(inst_pc), .fetch_fault(fetch_fault)
    );

    typedef struct { int due; logic [63:0] addr; } pend_t;

    int          n_cmp = 0, n_err = 0;
    int          cyc = 0, mem_lat = 1;
    int          acc_cnt = 0, resp_cnt = 0, pop_cnt = 0;
    pend_t       pend[$];
    logic [63:0] sb[$];

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_seq(input logic [63:0] base, input int n);
        for (int i = 0; i < n; i++) sb.push_back(base + 64'(4 * i));
    endtask

    task automatic nxt();
        @(posedge clk); #1;
    endtask

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // In-order memory: accept sampled mid-cycle, reply mem_lat cycles later
    initial begin
        imem_resp_valid = 0;
        imem_resp_data  = '0;
        forever begin
            @(negedge clk);
            if (rst) pend.delete();
            else begin
                if (imem_resp_valid) resp_cnt++;
                if (imem_req_valid && imem_req_ready) begin
                    pend.push_back('{cyc + mem_lat, imem_req_addr});
                    acc_cnt++;
                end
            end
            @(posedge clk); #1;
            if (pend.size() > 0 && pend[0].due <= cyc) begin
                imem_resp_valid = 1;
                imem_resp_data  = mem_word(pend[0].addr);
                void'(pend.pop_front());
            end else begin
                imem_resp_valid = 0;
                imem_resp_data  = '0;
            end
        end
    end

    // Decode-side monitor: every accepted head must match the scoreboard
    initial forever begin
        @(negedge clk);
        if (!rst && !redirect_valid && inst_valid && inst_ready) begin
            pop_cnt++;
            n_cmp++;
            assert (sb.size() != 0) else begin
                n_err++;
                $error("FAIL unexpected_inst: observed pc %0h expected none", inst_pc);
            end
            if (sb.size() != 0) begin
                logic [63:0] e;
                e = sb.pop_front();
                chk("inst_pc", inst_pc, e);
                chk("inst_data", 64'(inst_data), 64'(mem_word(e)));
            end
        end
    end

    initial begin
        int snap, vcnt;
        bit found;
        rst = 1; redirect_valid = 0; redirect_pc = '0;
        inst_ready = 1; imem_req_ready = 1;

        // Reset state
        repeat (3) nxt();
        @(negedge clk);
        chk("rst_inst_valid", 64'(inst_valid), 64'd0);
        chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
        chk("rst_fault", 64'(fetch_fault), 64'd0);
        chk("rst_inst_data", 64'(inst_data), 64'd0);
        chk("rst_inst_pc", inst_pc, 64'd0);

        // Stream from RESET_PC with latency 1
        nxt(); rst = 0; push_seq(64'h0, 40);
        @(negedge clk);
        chk("first_req_valid", 64'(imem_req_valid), 64'd1);
        chk("first_req_addr", imem_req_addr, 64'h0);
        nxt(); @(negedge clk);
        chk("lat_n1_inst_valid", 64'(inst_valid), 64'd0);
        nxt(); @(negedge clk);
        chk("lat_n2_inst_valid", 64'(inst_valid), 64'd1);
        chk("lat_n2_inst_pc", inst_pc, 64'h0);
        vcnt = 0;
        for (int i = 0; i < 8; i++) begin
            nxt(); @(negedge clk);
            if (inst_valid) vcnt++;
        end
        chk("throughput_8", 64'(vcnt), 64'd8);

        // Decode stall: exactly DEPTH held, requests stop
        nxt(); inst_ready = 0;
        repeat (9) nxt();
        @(negedge clk);
        chk("stall_req_valid", 64'(imem_req_valid), 64'd0);
        chk("stall_inst_valid", 64'(inst_valid), 64'd1);
        chk("stall_buffered", 64'(acc_cnt - pop_cnt), 64'd4);
        nxt(); inst_ready = 1;
        repeat (10) nxt();

        // Latency 3, redirect with two requests outstanding
        mem_lat = 3;
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk); #1;
            if (acc_cnt - resp_cnt == 2) found = 1;
        end
        chk("wait_outst2", 64'(found), 64'd1);
        nxt(); redirect_valid = 1; redirect_pc = 64'h100;
        sb.delete(); push_seq(64'h100, 40); snap = pop_cnt;
        @(negedge clk);
        chk("redir_r_req_valid", 64'(imem_req_valid), 64'd0);
        nxt(); redirect_valid = 0;
        @(negedge clk);
        chk("redir_r1_inst_valid", 64'(inst_valid), 64'd0);
        chk("redir_r1_req_valid", 64'(imem_req_valid), 64'd1);
        chk("redir_r1_req_addr", imem_req_addr, 64'h100);
        repeat (12) nxt();
        chk("redir_pops_seen", 64'(pop_cnt - snap >= 2), 64'd1);

        // Redirect colliding with a response and a pop
        mem_lat = 1;
        repeat (8) nxt();
        redirect_valid = 1; redirect_pc = 64'h200;
        sb.delete(); push_seq(64'h200, 40);
        @(negedge clk);
        chk("collide_cond", 64'(imem_resp_valid && inst_valid && inst_ready), 64'd1);
        nxt(); redirect_valid = 0;
        @(negedge clk);
        chk("collide_r1_inst_valid", 64'(inst_valid), 64'd0);
        chk("collide_r1_req_addr", imem_req_addr, 64'h200);
        repeat (8) nxt();

        // Misaligned redirect
        redirect_valid = 1; redirect_pc = 64'h102; sb.delete();
`ifdef IFETCH_ALIGN_CHECK_EN
        nxt(); redirect_valid = 0;
        @(negedge clk);
        chk("mis_fault", 64'(fetch_fault), 64'd1);
        chk("mis_req_valid", 64'(imem_req_valid), 64'd0);
        snap = acc_cnt;
        repeat (5) nxt();
        @(negedge clk);
        chk("mis_no_accepts", 64'(acc_cnt - snap), 64'd0);
        chk("mis_inst_valid", 64'(inst_valid), 64'd0);
        nxt(); redirect_valid = 1; redirect_pc = 64'h200; push_seq(64'h200, 40);
        nxt(); redirect_valid = 0;
        @(negedge clk);
        chk("realign_fault", 64'(fetch_fault), 64'd0);
        chk("realign_req_addr", imem_req_addr, 64'h200);
`else
        push_seq(64'h100, 40);
        nxt(); redirect_valid = 0;
        @(negedge clk);
        chk("mis_fault", 64'(fetch_fault), 64'd0);
        chk("mis_req_addr", imem_req_addr, 64'h100);
`endif
        repeat (8) nxt();

        // Reset mid-stream with a full FIFO
        inst_ready = 0;
        repeat (8) nxt();
        @(negedge clk);
        chk("full_inst_valid", 64'(inst_valid), 64'd1);
        chk("full_req_valid", 64'(imem_req_valid), 64'd0);
        nxt(); rst = 1; sb.delete();
        nxt();
        @(negedge clk);
        chk("mrst_inst_valid", 64'(inst_valid), 64'd0);
        chk("mrst_fault", 64'(fetch_fault), 64'd0);
        chk("mrst_inst_pc", inst_pc, 64'd0);
        nxt(); rst = 0; inst_ready = 1; push_seq(64'h0, 40);
        @(negedge clk);
        chk("mrst_req_valid", 64'(imem_req_valid), 64'd1);
        chk("mrst_req_addr", imem_req_addr, 64'h0);
        repeat (10) nxt();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
